// File: rtl/bist_lfsr_misr_ctrl.sv
// Logic BIST controller. A Galois LFSR drives the external CUT, and a MISR compacts the CUT responses.
// The final signature is then shifted out MSB first and compared against a golden value.
module bist_lfsr_misr_ctrl #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  LFSR_POLY    = 8'h1D,
  parameter logic [WIDTH-1:0]  MISR_POLY    = 8'h1D,
  parameter logic [WIDTH-1:0]  LFSR_SEED    = 8'h01,
  parameter int unsigned       NUM_PATTERNS = 14,
  parameter logic [WIDTH-1:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] cut_in,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             test_en,
  output logic             busy,
  output logic             sign_ser,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass
);

  localparam int unsigned PAT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [WIDTH-1:0] SEED = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] lfsr_step, misr_step;

  always_comb begin
    lfsr_step = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? LFSR_POLY : '0);
    misr_step = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? MISR_POLY : '0) ^ cut_resp;
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    shreg_d   = shreg_q;
    sig_d     = sig_q;
    pat_cnt_d = pat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          lfsr_d    = SEED;
          misr_d    = '0;
          pat_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d    = lfsr_step;
          misr_d    = misr_step;
          pat_cnt_d = pat_cnt_q + 1'b1;
          if (pat_cnt_q == PAT_LAST) begin
            state_d   = S_SHIFT;
            sig_d     = misr_step;
            shreg_d   = misr_step;
            bit_cnt_d = '0;
            pat_cnt_d = '0;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      misr_q    <= '0;
      shreg_q   <= '0;
      sig_q     <= '0;
      pat_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      shreg_q   <= shreg_d;
      sig_q     <= sig_d;
      pat_cnt_q <= pat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    cut_in    = (state_q == S_RUN) ? lfsr_q : '0;
    test_en   = (state_q == S_RUN);
    busy      = (state_q == S_RUN) || (state_q == S_SHIFT);
    sign_ser  = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    signature = sig_q;
    done      = (state_q == S_DONE);
    pass      = (state_q == S_DONE) && (sig_q == GOLDEN_SIG);
  end

endmodule

// File: tb/tb_bist_lfsr_misr_ctrl.sv
// Directed bench for bist_lfsr_misr_ctrl: a 4-bit instance driven from a vector table and hand sequences,
// plus a default-width instance with a zero seed.
module tb_bist_lfsr_misr_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       start, abort, inv;
  logic [3:0] cut_in, cut_resp, signature;
  logic       test_en, busy, sign_ser, done, pass;

  logic       start8, abort8;
  logic [7:0] cut_in8, cut_resp8, signature8;
  logic       test_en8, busy8, sign_ser8, done8, pass8;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign cut_resp  = inv ? ~cut_in : cut_in;
  assign cut_resp8 = cut_in8;

  bist_lfsr_misr_ctrl #(
    .WIDTH(4), .LFSR_POLY(4'h3), .MISR_POLY(4'h3), .LFSR_SEED(4'h1),
    .NUM_PATTERNS(3), .GOLDEN_SIG(4'h4)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
    .cut_in(cut_in), .cut_resp(cut_resp), .test_en(test_en), .busy(busy),
    .sign_ser(sign_ser), .signature(signature), .done(done), .pass(pass)
  );

  bist_lfsr_misr_ctrl #(
    .LFSR_SEED(8'h00)
  ) dut8 (
    .CLK(CLK), .RSTn(RSTn), .start(start8), .abort(abort8),
    .cut_in(cut_in8), .cut_resp(cut_resp8), .test_en(test_en8), .busy(busy8),
    .sign_ser(sign_ser8), .signature(signature8), .done(done8), .pass(pass8)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] cut_in;
    logic       test_en;
    logic       busy;
    logic       ser;
    logic       done;
    logic       pass;
    logic [3:0] sig;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic ab, logic [3:0] ci, logic te, logic bz,
                              logic sr, logic dn, logic ps, logic [3:0] sg);
    vec_t v;
    v.start = st; v.abort = ab; v.cut_in = ci; v.test_en = te; v.busy = bz;
    v.ser = sr; v.done = dn; v.pass = ps; v.sig = sg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] ci, input logic te, input logic bz,
                         input logic sr, input logic dn, input logic ps, input logic [3:0] sg);
    chk({nm, ".cut_in"}, 32'(cut_in), 32'(ci));
    chk({nm, ".test_en"}, 32'(test_en), 32'(te));
    chk({nm, ".busy"}, 32'(busy), 32'(bz));
    chk({nm, ".sign_ser"}, 32'(sign_ser), 32'(sr));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".pass"}, 32'(pass), 32'(ps));
    chk({nm, ".signature"}, 32'(signature), 32'(sg));
  endtask

  // Full run on the 4-bit instance; done must rise exactly 7 edges after the start edge.
  task automatic full_run(input string nm, input logic [3:0] sig_exp, input logic pass_exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("%s.done_e%0d", nm, k), 32'(done), 32'(k == 7));
    end
    chk({nm, ".signature"}, 32'(signature), 32'(sig_exp));
    chk({nm, ".pass"}, 32'(pass), 32'(pass_exp));
  endtask

  logic [7:0] seq8 [14];

  initial begin
    RSTn = 1'b0; start = 1'b0; abort = 1'b0; inv = 1'b0;
    start8 = 1'b0; abort8 = 1'b0;
    seq8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87};

    // Identity run, abort in DONE ignored, start+abort together, start held through RUN.
    vecs.push_back(mk(1, 0, 4'h1, 1, 1, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 4'h2, 1, 1, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 4'h4, 1, 1, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 1, 4'h4));
    vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 1, 4'h4));
    vecs.push_back(mk(1, 1, 4'h1, 1, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(1, 0, 4'h2, 1, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(1, 0, 4'h4, 1, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 4'h4));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 1, 4'h4));

    tick();
    tick();
    chk_all("reset", 4'h0, 0, 0, 0, 0, 0, 4'h0);
    chk("reset8.cut_in", 32'(cut_in8), 32'h0);
    chk("reset8.done", 32'(done8), 32'h0);
    RSTn = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].cut_in, vecs[i].test_en, vecs[i].busy,
              vecs[i].ser, vecs[i].done, vecs[i].pass, vecs[i].sig);
    end
    start = 1'b0; abort = 1'b0;

    inv = 1'b1;
    full_run("invert", 4'hF, 1'b0);
    inv = 1'b0;

    // Reset during the second RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid.cut_in_before", 32'(cut_in), 32'h2);
    RSTn = 1'b0;
    tick();
    chk_all("rst_mid", 4'h0, 0, 0, 0, 0, 0, 4'h0);
    RSTn = 1'b1;
    tick();
    full_run("after_rst", 4'h4, 1'b1);

    // Abort while SHIFT is presenting bit 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("abort.in_shift", 32'({test_en, busy}), 32'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("abort", 4'h0, 0, 0, 0, 0, 0, 4'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort.idle%0d", k), 32'({done, busy}), 32'b00);
    end
    full_run("after_abort", 4'h4, 1'b1);

    // Default-width instance with a zero seed.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("w8.first_cut_in", 32'(cut_in8), 32'h01);
    for (int i = 1; i < 14; i++) begin
      tick();
      chk($sformatf("w8.cut_in%0d", i), 32'(cut_in8), 32'(seq8[i]));
      chk($sformatf("w8.test_en%0d", i), 32'(test_en8), 32'h1);
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("w8.shift%0d", j), 32'({test_en8, busy8, done8}), 32'b010);
    end
    tick();
    chk("w8.done", 32'({busy8, done8}), 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
